// File: rtl/reg_dr_if.sv
// Bus bundle for reg_dr: instruction word, memory data and timing state in,
// DR contents and zero flag out.
interface reg_dr_if #(
   parameter int DW = 16
);
   logic [15:0]   IN_IR;
   logic [DW-1:0] IN;
   logic [2:0]    t;
   logic [DW-1:0] Q_DR;
   logic          Z_DR;

   modport master (output IN_IR, IN, t, input Q_DR, Z_DR);
   modport slave  (input IN_IR, IN, t, output Q_DR, Z_DR);
endinterface

// File: rtl/reg_dr.sv
// Data register DR: loaded from memory at T4 of AND/ADD/LDA/ISZ, incremented at T5 of ISZ.
// Optional zero flag on Z_DR enabled by macro REG_DR_ZFLAG_EN.
module reg_dr #(
   parameter int DW = 16
) (
   input logic    CLK,
   input logic    RST,
   reg_dr_if.slave bus
);
   logic [2:0]    d;
   logic          load;
   logic          incr;
   logic [DW-1:0] dr_q;

   // The indirect bit IN_IR[15] plays no part in the decision.
   assign d    = bus.IN_IR[14:12];
   assign load = (bus.t == 3'd4) &&
                 ((d == 3'd0) || (d == 3'd1) || (d == 3'd2) || (d == 3'd6));
   assign incr = (bus.t == 3'd5) && (d == 3'd6);

   always_ff @(posedge CLK) begin
      if (RST) begin
         dr_q <= '0;
      end else if (load) begin
         dr_q <= bus.IN;
      end else if (incr) begin
         dr_q <= dr_q + 1'b1;
      end
   end

   assign bus.Q_DR = dr_q;

`ifdef REG_DR_ZFLAG_EN
   assign bus.Z_DR = (dr_q == '0);
`else
   assign bus.Z_DR = 1'b0;
`endif
endmodule

// File: tb/tb_reg_dr.sv
// Self-checking bench for reg_dr: per-cycle model comparison plus literal vectors.
module tb_reg_dr;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   reg_dr_if #(.DW(DW)) bus ();

   reg_dr #(.DW(DW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model of DR, advanced from the sampled inputs at each edge.
   logic [DW-1:0] model_q = '0;
   bit            model_valid = 1'b0;

   function automatic logic zexp(input logic [DW-1:0] q);
`ifdef REG_DR_ZFLAG_EN
      return (q == 0);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      int op;
      op = int'(bus.IN_IR[14:12]);
      if (rst) begin
         model_q = '0;
         model_valid = 1'b1;
      end else if (bus.t == 3'd4 && op inside {0, 1, 2, 6}) begin
         model_q = bus.IN;
      end else if (bus.t == 3'd5 && op == 6) begin
         model_q = (model_q == {DW{1'b1}}) ? '0 : model_q + 1;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (bus.Q_DR !== model_q || bus.Z_DR !== zexp(model_q)) begin
            failures++;
            $display("FAIL model_cmp t=%0t Q_DR=%h Z_DR=%b expected Q_DR=%h Z_DR=%b",
                     $time, bus.Q_DR, bus.Z_DR, model_q, zexp(model_q));
         end
      end
   end

   // Drive one cycle of inputs, clock it in, then check a hand-computed result.
   task automatic step(input string name, input logic r, input logic [15:0] ir,
                       input logic [DW-1:0] din, input logic [2:0] tt,
                       input logic [DW-1:0] exp_q, input logic exp_z);
      @(negedge clk);
      rst = r;
      bus.IN_IR = ir;
      bus.IN = din;
      bus.t = tt;
      @(posedge clk);
      #1;
      checks++;
      if (bus.Q_DR !== exp_q || bus.Z_DR !== exp_z) begin
         failures++;
         $display("FAIL %s Q_DR=%h Z_DR=%b expected Q_DR=%h Z_DR=%b",
                  name, bus.Q_DR, bus.Z_DR, exp_q, exp_z);
      end
   endtask

   logic zf;

   initial begin
`ifdef REG_DR_ZFLAG_EN
      zf = 1'b1;
`else
      zf = 1'b0;
`endif
      bus.IN_IR = '0;
      bus.IN = '0;
      bus.t = 3'd0;

      step("reset",         1'b1, 16'h0000, 16'h1234, 3'd4, 16'h0000, zf);
      step("hold_t0",       1'b0, 16'h0000, 16'h1234, 3'd0, 16'h0000, zf);
      step("load_and",      1'b0, 16'h0000, 16'h1234, 3'd4, 16'h1234, 1'b0);
      step("isz_inc",       1'b0, 16'h6123, 16'h0000, 3'd5, 16'h1235, 1'b0);
      step("isz_inc_ind",   1'b0, 16'hE123, 16'h0000, 3'd5, 16'h1236, 1'b0);
      step("isz_hold_t6",   1'b0, 16'h6000, 16'h9999, 3'd6, 16'h1236, 1'b0);
      step("load_isz_ff",   1'b0, 16'h6000, 16'hFFFF, 3'd4, 16'hFFFF, 1'b0);
      step("isz_wrap",      1'b0, 16'h6000, 16'h0000, 3'd5, 16'h0000, zf);
      step("load_add",      1'b0, 16'h1000, 16'h5555, 3'd4, 16'h5555, 1'b0);
      step("no_load_op7",   1'b0, 16'h7800, 16'hABCD, 3'd4, 16'h5555, 1'b0);
      step("no_load_op3",   1'b0, 16'h3000, 16'hABCD, 3'd4, 16'h5555, 1'b0);
      step("no_load_op4",   1'b0, 16'h4000, 16'hABCD, 3'd4, 16'h5555, 1'b0);
      step("no_load_op5",   1'b0, 16'h5000, 16'hABCD, 3'd4, 16'h5555, 1'b0);
      step("no_inc_add",    1'b0, 16'h1000, 16'hABCD, 3'd5, 16'h5555, 1'b0);
      step("load_lda_ind",  1'b0, 16'hA000, 16'h00A5, 3'd4, 16'h00A5, 1'b0);
      step("hold_t3",       1'b0, 16'h0000, 16'h7777, 3'd3, 16'h00A5, 1'b0);
      step("hold_t7",       1'b0, 16'h6000, 16'h7777, 3'd7, 16'h00A5, 1'b0);
      step("load_lda",      1'b0, 16'h2000, 16'h0010, 3'd4, 16'h0010, 1'b0);
      step("rst_beats_inc", 1'b1, 16'h6000, 16'h0000, 3'd5, 16'h0000, zf);
      step("post_rst_hold", 1'b0, 16'h6000, 16'h4321, 3'd0, 16'h0000, zf);
      step("inc_from_zero", 1'b0, 16'h6000, 16'h4321, 3'd5, 16'h0001, 1'b0);
      step("rst_beats_load",1'b1, 16'h0000, 16'h4321, 3'd4, 16'h0000, zf);

      // A sweep of every opcode at every timing state against the model.
      for (int tt = 0; tt < 8; tt++) begin
         for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            rst = 1'b0;
            bus.IN_IR = {1'(op % 2), 3'(op), 12'h5A5};
            bus.IN = 16'(16'h0100 * (op + 1) + tt);
            bus.t = 3'(tt);
         end
      end

      @(negedge clk);
      bus.t = 3'd0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete, expected finish before 100000");
      $fatal(1);
   end
endmodule

// File: doc/reg_dr.md
REG_DR -- requirements
Module: reg_dr

Interface
REQ-001 Parameter: DW, default 16, width of the data register and its load input; IN_IR is always 16 bits.
REQ-002 CLK  input  1  system clock; all state updates occur on its rising edge.
REQ-003 RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 IN_IR  input  16  current instruction word; bit 15 = indirect flag I, bits 14:12 = opcode D, bits 11:0 = address.
REQ-005 IN  input  DW  memory read data (M[AR]).
REQ-006 t  input  3  sequence-counter timing state, value n = Tn (T0..T7).
REQ-007 Q_DR  output  DW  registered contents of DR.
REQ-008 Z_DR  output  1  DR-zero flag (see Configuration).

Function
REQ-009 Opcode decode: D = IN_IR[14:12]; IN_IR[15] is ignored for all decisions.
REQ-010 Load: at a rising edge with t==4 and D in {0 AND, 1 ADD, 2 LDA, 6 ISZ}, Q_DR <= IN.
REQ-011 Increment: at a rising edge with t==5 and D==6 (ISZ), Q_DR <= Q_DR + 1, modulo 2^DW.
REQ-012 Wrap-around: increment of all-ones yields all-zeros, no carry output.
REQ-013 Hold: every other combination (any t other than 4/5, t==4 with D in {3,4,5,7}, t==5 with D!=6) leaves Q_DR unchanged.
REQ-014 Load and increment are mutually exclusive by construction (distinct t values); no priority logic beyond reset is required.
REQ-015 Latency: Q_DR reflects a load or increment one edge after the qualifying t/IN_IR values are applied; no combinational path from IN to Q_DR.
REQ-016 Inputs are sampled only at the rising edge; IN changes between edges have no effect.

Reset
REQ-017 When RST==1 at a rising edge, Q_DR <= 0 regardless of t, IN_IR, IN.
REQ-018 RST has priority over load and increment; reset asserted during an ISZ T5 cycle discards the increment.
REQ-019 After reset deassertion, Q_DR holds 0 until the next qualifying load or increment.

Configuration
REQ-020 Macro REG_DR_ZFLAG_EN: when defined, Z_DR = 1 exactly when Q_DR == 0 (combinational from the register, no extra cycle).
REQ-021 When REG_DR_ZFLAG_EN is undefined, Z_DR is driven constant 0 and no comparator logic exists; Q_DR behaviour is identical in both builds.

Verification
REQ-022 RST=1 for one edge with IN=16'h1234, t=4, IN_IR=16'h0000 -> Q_DR=16'h0000, Z_DR=1 (flag build).
REQ-023 t=0, IN_IR=16'h0000, IN=16'h1234 -> Q_DR unchanged (16'h0000); then t=4, IN=16'h1234 -> Q_DR=16'h1234 after one edge.
REQ-024 Q_DR=16'h1234, t=5, IN_IR=16'h6123 -> Q_DR=16'h1235; same with IN_IR=16'hE123 (I=1) -> also increments.
REQ-025 Load IN=16'hFFFF at t=4 with IN_IR=16'h6000, then t=5 -> Q_DR=16'h0000, Z_DR=1 (flag build) / Z_DR=0 (non-flag build).
REQ-026 t=4 with IN_IR=16'h7800 or 16'h3000 and IN=16'hABCD -> Q_DR unchanged; t=5 with IN_IR=16'h1000 -> Q_DR unchanged.
REQ-027 Q_DR=16'h0010, t=5, IN_IR=16'h6000, RST=1 on same edge -> Q_DR=16'h0000 (reset wins).
